// File: rtl/latch_array_test_seq.sv
// latch_array_test_seq: two-pass write/read-compare sequencer for an external latch array.
// Ports: start/pattern/abort in, busy/done/pass/err_count/first_err_addr out (tile side);
//        lat_addr/lat_wdata/lat_gate out, lat_rdata in (array side). All outputs registered.
module latch_array_test_seq #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int SETTLE   = 2,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        pattern,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] lat_addr,
  output logic [DATA_W-1:0] lat_wdata,
  output logic              lat_gate,
  input  logic [DATA_W-1:0] lat_rdata
);

  localparam int CNT_MAX = (SETTLE > READ_LAT) ? SETTLE : READ_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_GATE,
    S_WR_HOLD,
    S_RD_WAIT,
    S_RD_CMP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pidx_q, pidx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        pat_q, pat_d;
  logic [7:0]        err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              gate_q, gate_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;

  logic              last_addr;
  logic              running;
  logic              mismatch;
  logic [DATA_W-1:0] exp_word;

  // Pattern word for address a; inv selects the complemented second pass.
  function automatic logic [DATA_W-1:0] pat_word(input logic [1:0] sel,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic inv);
    logic [DATA_W-1:0] w;
    w = '0;
    case (sel)
      2'd0: w = '0;
      2'd1: begin
        // bit 0 set on even addresses (0x55 style), whole word flips on odd ones
        for (int i = 0; i < DATA_W; i++) w[i] = ((i % 2) == 0) ^ a[0];
      end
      2'd2: begin
        for (int i = 0; i < DATA_W; i++) w[i] = (i < ADDR_W) ? a[i % ADDR_W] : 1'b0;
      end
      default: w = '1;
    endcase
    return inv ? ~w : w;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pidx_d      = pidx_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    err_d       = err_q;
    ferr_d      = ferr_q;
    pass_d      = pass_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;

    last_addr = (addr_q == {ADDR_W{1'b1}});
    running   = (state_q != S_IDLE) && (state_q != S_DONE);
    exp_word  = pat_word(pat_q, addr_q, pidx_q);
    mismatch  = (state_q == S_RD_CMP) && (lat_rdata != exp_word);

    if (mismatch) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      // err_q can never return to zero within a test, so zero marks the first miss
      if (err_q == 8'd0) ferr_d = addr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR_SETUP;
          pat_d   = pattern;
          addr_d  = '0;
          pidx_d  = 1'b0;
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_GATE;
        cnt_d   = CNT_W'(SETTLE - 1);
      end
      S_WR_GATE: begin
        if (cnt_q == '0) state_d = S_WR_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_WR_HOLD: begin
        if (last_addr) begin
          state_d = S_RD_WAIT;
          addr_d  = '0;
          cnt_d   = CNT_W'(READ_LAT - 1);
        end else begin
          state_d = S_WR_SETUP;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) state_d = S_RD_CMP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RD_CMP: begin
        if (last_addr) begin
          if (pidx_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WR_SETUP;
            pidx_d  = 1'b1;
            addr_d  = '0;
          end
        end else begin
          state_d = S_RD_WAIT;
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = CNT_W'(READ_LAT - 1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Verdict includes the final compare of this cycle via err_d
    if (state_d == S_DONE) pass_d = (err_d == 8'd0);

    if (abort && running) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end

    // Array-side outputs change only when entering setup or read-wait, so the
    // address/data are frozen through the whole gate pulse and the cycle it falls.
    if (state_d == S_WR_SETUP) begin
      lat_addr_d  = addr_d;
      lat_wdata_d = pat_word(pat_d, addr_d, pidx_d);
    end else if (state_d == S_RD_WAIT) begin
      lat_addr_d  = addr_d;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    gate_d = (state_d == S_WR_GATE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pidx_q      <= 1'b0;
      cnt_q       <= '0;
      pat_q       <= '0;
      err_q       <= '0;
      ferr_q      <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gate_q      <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pidx_q      <= pidx_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      err_q       <= err_d;
      ferr_q      <= ferr_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      gate_q      <= gate_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign lat_addr       = lat_addr_q;
  assign lat_wdata      = lat_wdata_q;
  assign lat_gate       = gate_q;

endmodule
